// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: op and state encodings, plus a bit-reverse helper.
package shift_pkg;

  localparam logic [1:0] SHIFT_SLL  = 2'b00;
  localparam logic [1:0] SHIFT_SRA  = 2'b01;
  localparam logic [1:0] SHIFT_SRL  = 2'b10;
  localparam logic [1:0] SHIFT_PASS = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic logic [31:0] bit_reverse(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_unit.sv
// Combinational 32-bit logarithmic shifter (16/8/4/2/1 stages) for SLL, SRA, SRL and PASS.
module shift_unit
  import shift_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] data,
  input  logic [4:0]  shamt,
  output logic [31:0] result
);

  logic        fill;
  logic        shift_left;
  logic [5:0][31:0] stage;

  assign shift_left = (op == SHIFT_SLL);
  assign fill       = (op == SHIFT_SRA) ? data[31] : 1'b0;

  // Left shifts run through the same right-shifting ladder on bit-reversed data.
  assign stage[0] = shift_left ? bit_reverse(data) : data;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_stage
      localparam int SH = 16 >> gi;
      assign stage[gi+1] = shamt[4-gi] ? {{SH{fill}}, stage[gi][31:SH]} : stage[gi];
    end
  endgenerate

  always_comb begin
    result = stage[5];
    if (op == SHIFT_PASS) begin
      result = data;
    end else if (shift_left) begin
      result = bit_reverse(stage[5]);
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift unit between two requesters, with a single
// registered result slot that can be refilled in the same cycle it is consumed.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [31:0]      req_data0,
  input  logic [31:0]      req_data1,
  input  logic [4:0]       req_shamt0,
  input  logic [4:0]       req_shamt1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag
);

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic [31:0]        result_q, result_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  logic               free;
  logic               fire;
  logic               accept;
  logic               winner;
  logic [1:0]         sel_op;
  logic [31:0]        sel_data;
  logic [4:0]         sel_shamt;
  logic [TAG_W-1:0]   sel_tag;
  logic [31:0]        shift_out;

  // Only the winning port's payload reaches the shifter, so the loser's inputs are don't-care.
  assign sel_op    = winner ? req_op1    : req_op0;
  assign sel_data  = winner ? req_data1  : req_data0;
  assign sel_shamt = winner ? req_shamt1 : req_shamt0;
  assign sel_tag   = winner ? req_tag1   : req_tag0;

  shift_unit u_shift_unit (
    .op     (sel_op),
    .data   (sel_data),
    .shamt  (sel_shamt),
    .result (shift_out)
  );

  always_comb begin
    fire         = reset && (state_q == ST_HOLD) && rsp_ready[owner_q];
    free         = reset && ((state_q == ST_IDLE) || rsp_ready[owner_q]);
    winner       = (&req_valid) ? ~last_grant_q : req_valid[1];
    accept       = free && (|req_valid);
    req_ready    = accept ? (winner ? 2'b10 : 2'b01) : 2'b00;

    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    tag_d        = tag_q;

    if (accept) begin
      state_d      = ST_HOLD;
      owner_d      = winner;
      last_grant_d = winner;
      result_d     = shift_out;
      tag_d        = sel_tag;
    end else if (fire) begin
      state_d      = ST_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      tag_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
      tag_q        <= tag_d;
    end
  end

  assign rsp_valid  = (reset && (state_q == ST_HOLD)) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = result_q;
  assign rsp_tag    = tag_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and randomized bench for shift_arbiter against a transaction-level reference model.
module tb_shift_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_op0, req_op1;
  logic [31:0] req_data0, req_data1;
  logic [4:0]  req_shamt0, req_shamt1;
  logic [3:0]  req_tag0, req_tag1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the result slot and round-robin pointer.
  bit          m_full;
  bit          m_owner;
  bit          m_last;
  logic [31:0] m_res;
  logic [3:0]  m_tag;

  always #5 clock = ~clock;

  shift_arbiter #(.TAG_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .req_shamt0 (req_shamt0),
    .req_shamt1 (req_shamt1),
    .req_tag0   (req_tag0),
    .req_tag1   (req_tag1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag)
  );

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] sh);
    case (op)
      2'b00:   return d << sh;
      2'b01:   return 32'($signed(d) >>> sh);
      2'b10:   return d >> sh;
      default: return d;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] sh, input logic [3:0] tg);
    if (p == 0) begin
      req_op0 = op; req_data0 = d; req_shamt0 = sh; req_tag0 = tg;
    end else begin
      req_op1 = op; req_data1 = d; req_shamt1 = sh; req_tag1 = tg;
    end
  endtask

  task automatic rand_ports();
    set_port(0, 2'($urandom), $urandom, 5'($urandom), 4'($urandom));
    set_port(1, 2'($urandom), $urandom, 5'($urandom), 4'($urandom));
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model on the edge.
  task automatic cycle();
    logic [1:0] exp_ready;
    logic [1:0] exp_rspv;
    bit         free;
    bit         w;
    @(negedge clock);
    exp_ready = 2'b00;
    exp_rspv  = 2'b00;
    w         = 1'b0;
    if (reset) begin
      exp_rspv = m_full ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      free = !m_full || rsp_ready[m_owner];
      if (req_valid == 2'b11) w = !m_last;
      else                    w = req_valid[1];
      if (free && req_valid != 2'b00) exp_ready = w ? 2'b10 : 2'b01;
    end
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rspv));
    if (reset && m_full) begin
      check("rsp_result", 64'(rsp_result), 64'(m_res));
      check("rsp_tag", 64'(rsp_tag), 64'(m_tag));
    end
    $display("t=%0t rst=%b vld=%b rdy=%b rspv=%b rsprdy=%b res=%h tag=%h",
             $time, reset, req_valid, req_ready, rsp_valid, rsp_ready, rsp_result, rsp_tag);
    @(posedge clock);
    if (!reset) begin
      m_full = 0; m_owner = 0; m_last = 1; m_res = '0; m_tag = '0;
    end else if (exp_ready != 2'b00) begin
      m_full  = 1;
      m_owner = w;
      m_last  = w;
      m_res   = w ? ref_shift(req_op1, req_data1, req_shamt1)
                  : ref_shift(req_op0, req_data0, req_shamt0);
      m_tag   = w ? req_tag1 : req_tag0;
    end else if (m_full && rsp_ready[m_owner]) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic send1(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                       input logic [3:0] tg, input logic [31:0] exp, input string name);
    set_port(1, op, d, sh, tg);
    req_valid = 2'b10;
    cycle();
    req_valid = 2'b00;
    check(name, 64'(rsp_result), 64'(exp));
    cycle();
  endtask

  initial begin
    m_full = 0; m_owner = 0; m_last = 1; m_res = '0; m_tag = '0;
    reset = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    rand_ports();

    // Reset with requests present: nothing accepted.
    repeat (3) cycle();
    check("reset_result", 64'(rsp_result), 64'h0);
    reset = 1'b1;
    req_valid = 2'b00;
    cycle();

    // Single SRA on port 0.
    set_port(0, 2'b01, 32'h8000_0000, 5'd4, 4'd3);
    req_valid = 2'b01;
    cycle();
    req_valid = 2'b00;
    check("sra_valid", 64'(rsp_valid), 64'h1);
    check("sra_result", 64'(rsp_result), 64'hF800_0000);
    check("sra_tag", 64'(rsp_tag), 64'h3);
    cycle();

    // Op coverage on port 1.
    send1(2'b00, 32'h0000_00F1, 5'd31, 4'd1, 32'h8000_0000, "sll31");
    send1(2'b10, 32'hF000_0000, 5'd28, 4'd2, 32'h0000_000F, "srl28");
    send1(2'b11, 32'h0000_00F1, 5'd9,  4'd4, 32'h0000_00F1, "pass");
    send1(2'b00, 32'h0000_00F1, 5'd0,  4'd5, 32'h0000_00F1, "sll0");
    send1(2'b01, 32'h8000_00F1, 5'd0,  4'd6, 32'h8000_00F1, "sra0");
    send1(2'b10, 32'h8000_00F1, 5'd0,  4'd7, 32'h8000_00F1, "srl0");

    // Conflict right after reset: port 0 first, then alternation with no bubble.
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 8; i++) begin
      rand_ports();
      cycle();
    end

    // Backpressure on a port-0 result while port 1 waits; includes the wrong-ready case.
    req_valid = 2'b00;
    cycle();
    cycle();
    set_port(0, 2'b00, 32'h1234_5678, 5'd4, 4'hA);
    req_valid = 2'b01;
    cycle();
    set_port(1, 2'b10, 32'hCAFE_0000, 5'd16, 4'hB);
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    cycle();
    rsp_ready = 2'b10;
    cycle();
    cycle();
    check("bp_held", 64'(rsp_result), 64'h2345_6780);
    rsp_ready = 2'b01;
    cycle();
    req_valid = 2'b00;
    check("bp_next", 64'(rsp_result), 64'h0000_CAFE);
    check("bp_owner", 64'(rsp_valid), 64'h2);
    rsp_ready = 2'b11;
    cycle();

    // Reset while holding a port-1 result.
    set_port(1, 2'b11, 32'h5555_AAAA, 5'd0, 4'h9);
    req_valid = 2'b10;
    cycle();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check("rst_hold_valid", 64'(rsp_valid), 64'h0);
    check("rst_hold_result", 64'(rsp_result), 64'h0);
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    rand_ports();
    cycle();
    check("rst_first_grant", 64'(rsp_valid), 64'h1);

    // Randomized traffic and backpressure.
    for (int i = 0; i < 300; i++) begin
      req_valid = 2'($urandom);
      rsp_ready = 2'($urandom);
      rand_ports();
      reset = ($urandom_range(0, 49) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
